// File: rtl/im_loader.sv
// Instruction-memory loader: packs WORD_WIDTH words into INSTR_WIDTH instructions
// and writes them to sequential rows. Optional write checksum via IM_LOADER_CHECKSUM_EN.
module im_loader #(
  parameter int unsigned IM_ADDR_WIDTH = 4,
  parameter int unsigned INSTR_WIDTH   = 26,
  parameter int unsigned WORD_WIDTH    = 8
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     clear_i,
  input  logic                     lock_i,
  input  logic                     word_valid_i,
  output logic                     word_ready_o,
  input  logic [WORD_WIDTH-1:0]    word_i,
  output logic                     im_we_o,
  output logic [IM_ADDR_WIDTH-1:0] im_addr_o,
  output logic [INSTR_WIDTH-1:0]   im_data_o,
  output logic [IM_ADDR_WIDTH:0]   instr_cnt_o,
  output logic                     full_o,
  output logic [INSTR_WIDTH-1:0]   checksum_o
);

  localparam int unsigned NW = (INSTR_WIDTH + WORD_WIDTH - 1) / WORD_WIDTH;
  localparam int unsigned KW = (NW > 1) ? $clog2(NW) : 1;
  localparam int unsigned CW = IM_ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    WRITE   = 2'd1,
    FULL    = 2'd2
  } state_e;

  state_e                   state_q;
  logic [KW-1:0]            k_q;
  logic [IM_ADDR_WIDTH-1:0] ptr_q;
  logic [INSTR_WIDTH-1:0]   asm_q;
  logic [CW-1:0]            cnt_q;

  logic                     accept;
  logic                     commit;
  logic [31:0]              shamt;
  logic [INSTR_WIDTH-1:0]   lane_mask;
  logic [INSTR_WIDTH-1:0]   lane_data;
  logic [INSTR_WIDTH-1:0]   asm_nxt;

  // Acceptance depends only on registered state plus the lock/clear controls.
  assign word_ready_o = (state_q == COLLECT) && !lock_i && !clear_i;
  assign accept       = word_valid_i && word_ready_o;
  assign commit       = (state_q == WRITE) && !clear_i;

  assign im_we_o     = commit;
  assign im_addr_o   = ptr_q;
  assign im_data_o   = asm_q;
  assign instr_cnt_o = cnt_q;
  assign full_o      = (state_q == FULL);

  // Word k lands at bit k*WORD_WIDTH; the shift naturally drops bits past INSTR_WIDTH.
  assign shamt     = 32'(k_q) * 32'(WORD_WIDTH);
  assign lane_mask = INSTR_WIDTH'({WORD_WIDTH{1'b1}}) << shamt;
  assign lane_data = INSTR_WIDTH'(word_i) << shamt;
  assign asm_nxt   = (asm_q & ~lane_mask) | (lane_data & lane_mask);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= COLLECT;
      k_q     <= '0;
      ptr_q   <= '0;
      asm_q   <= '0;
      cnt_q   <= '0;
    end else if (clear_i) begin
      state_q <= COLLECT;
      k_q     <= '0;
      ptr_q   <= '0;
      asm_q   <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        COLLECT: begin
          if (accept) begin
            asm_q <= asm_nxt;
            if (k_q == KW'(NW - 1)) begin
              k_q     <= '0;
              state_q <= WRITE;
            end else begin
              k_q <= k_q + KW'(1);
            end
          end
        end
        WRITE: begin
          cnt_q <= cnt_q + CW'(1);
          if (&ptr_q) begin
            state_q <= FULL;
          end else begin
            ptr_q   <= ptr_q + IM_ADDR_WIDTH'(1);
            state_q <= COLLECT;
          end
        end
        FULL: begin
          state_q <= FULL;
        end
        default: begin
          state_q <= COLLECT;
        end
      endcase
    end
  end

`ifdef IM_LOADER_CHECKSUM_EN
  logic [INSTR_WIDTH-1:0] cks_q;

  // Accumulates exactly the instructions the memory captures.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cks_q <= '0;
    end else if (clear_i) begin
      cks_q <= '0;
    end else if (commit) begin
      cks_q <= cks_q ^ asm_q;
    end
  end

  assign checksum_o = cks_q;
`else
  assign checksum_o = '0;
`endif

  a_we_single_cycle: assert property (@(posedge clk_i) disable iff (!rst_ni)
    im_we_o |=> !im_we_o);

  a_full_blocks_input: assert property (@(posedge clk_i) disable iff (!rst_ni)
    full_o |-> !word_ready_o);

  a_cnt_bounded: assert property (@(posedge clk_i) disable iff (!rst_ni)
    instr_cnt_o <= CW'(2 ** IM_ADDR_WIDTH));

endmodule

// File: tb/tb_im_loader.sv
// Randomized scoreboard bench for im_loader: a word-queue reference model predicts
// acceptance and memory writes; a negedge monitor pops and checks every write pulse.
module tb_im_loader;

  localparam int AW   = 4;
  localparam int IW   = 26;
  localparam int WW   = 8;
  localparam int NW   = 4;
  localparam int ROWS = 16;

  logic          clk_i = 1'b0;
  logic          rst_ni = 1'b0;
  logic          clear_i = 1'b0;
  logic          lock_i = 1'b0;
  logic          word_valid_i = 1'b0;
  logic          word_ready_o;
  logic [WW-1:0] word_i = '0;
  logic          im_we_o;
  logic [AW-1:0] im_addr_o;
  logic [IW-1:0] im_data_o;
  logic [AW:0]   instr_cnt_o;
  logic          full_o;
  logic [IW-1:0] checksum_o;

  im_loader dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .clear_i      (clear_i),
    .lock_i       (lock_i),
    .word_valid_i (word_valid_i),
    .word_ready_o (word_ready_o),
    .word_i       (word_i),
    .im_we_o      (im_we_o),
    .im_addr_o    (im_addr_o),
    .im_data_o    (im_data_o),
    .instr_cnt_o  (instr_cnt_o),
    .full_o       (full_o),
    .checksum_o   (checksum_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [IW-1:0] data;
  } wr_t;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  wr_t           exp_q[$];
  logic [WW-1:0] m_buf[$];
  int            m_rows;
  bit            m_full;
  bit            m_bubble;
  logic [IW-1:0] m_pend;
  logic [IW-1:0] m_cks;
  wr_t           mon_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [IW-1:0] pack_words();
    longint unsigned v = 0;
    for (int i = 0; i < m_buf.size(); i++)
      v += longint'(m_buf[i]) * (longint'(1) << (WW * i));
    return IW'(v % (longint'(1) << IW));
  endfunction

  function automatic logic [IW-1:0] exp_cks();
`ifdef IM_LOADER_CHECKSUM_EN
    return m_cks;
`else
    return '0;
`endif
  endfunction

  task automatic model_reset();
    m_buf.delete();
    m_rows   = 0;
    m_full   = 1'b0;
    m_bubble = 1'b0;
    m_pend   = '0;
    m_cks    = '0;
  endtask

  // One clock cycle: drive at posedge+1, check at negedge, advance the model at posedge.
  task automatic step(input bit v, input logic [WW-1:0] w, input bit lk, input bit clr);
    bit er;
    bit hs;
    word_valid_i = v;
    word_i       = w;
    lock_i       = lk;
    clear_i      = clr;
    er = !lk && !clr && !m_full && !m_bubble;
    hs = v && er;
    if (clr && m_bubble && exp_q.size() > 0) void'(exp_q.pop_back());
    @(negedge clk_i);
    check("word_ready", word_ready_o, er);
    check("full", full_o, m_full);
    check("instr_cnt", instr_cnt_o, m_rows);
    check("im_addr", im_addr_o, m_full ? ROWS - 1 : m_rows);
    check("checksum", checksum_o, exp_cks());
    @(posedge clk_i);
    if (clr) begin
      model_reset();
    end else if (m_bubble) begin
      m_rows++;
      m_cks ^= m_pend;
      m_bubble = 1'b0;
      if (m_rows == ROWS) m_full = 1'b1;
    end else if (hs) begin
      m_buf.push_back(w);
      if (m_buf.size() == NW) begin
        m_pend = pack_words();
        exp_q.push_back('{addr: AW'(m_rows), data: m_pend});
        m_buf.delete();
        m_bubble = 1'b1;
      end
    end
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, WW'($urandom), 1'b0, 1'b0);
  endtask

  // Asserted mid-cycle; outputs must reach reset values without a clock edge.
  task automatic do_reset();
    word_valid_i = 1'b0;
    lock_i       = 1'b0;
    clear_i      = 1'b0;
    rst_ni       = 1'b0;
    #1;
    check("rst_ready", word_ready_o, 1'b1);
    check("rst_we", im_we_o, 1'b0);
    check("rst_addr", im_addr_o, 0);
    check("rst_data", im_data_o, 0);
    check("rst_cnt", instr_cnt_o, 0);
    check("rst_full", full_o, 1'b0);
    check("rst_cks", checksum_o, 0);
    model_reset();
    exp_q.delete();
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  task automatic stream(input int n);
    for (int i = 0; i < n; i++) step(1'b1, WW'($urandom), 1'b0, 1'b0);
  endtask

  // Scoreboard monitor: every write pulse must match the oldest predicted write.
  always @(negedge clk_i) begin
    if (rst_ni && im_we_o) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", {im_addr_o, im_data_o}, 0);
      end else begin
        mon_e = exp_q.pop_front();
        check("wr_addr", im_addr_o, mon_e.addr);
        check("wr_data", im_data_o, mon_e.data);
      end
    end
  end

  initial begin
    model_reset();
    @(posedge clk_i);
    #1;
    do_reset();

    // Basic assembly: 0x11,0x22,0x33,0xFF -> 0x3332211 at addr 0
    step(1'b1, 8'h11, 1'b0, 1'b0);
    step(1'b1, 8'h22, 1'b0, 1'b0);
    step(1'b1, 8'h33, 1'b0, 1'b0);
    step(1'b1, 8'hFF, 1'b0, 1'b0);
    idle(3);

    // Fill all rows with valid held high, then probe beyond full
    step(1'b0, '0, 1'b0, 1'b1);
    stream(ROWS * (NW + 1) + 6);
    check("full_reached", full_o, 1'b1);

    // Clear while full: ready returns the following cycle
    step(1'b1, 8'h5A, 1'b0, 1'b1);
    stream(2);
    idle(6);

    // Partial instruction held across a lock
    step(1'b0, '0, 1'b0, 1'b1);
    step(1'b1, 8'hA1, 1'b0, 1'b0);
    step(1'b1, 8'hB2, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, WW'($urandom), 1'b1, 1'b0);
    step(1'b1, 8'hC3, 1'b0, 1'b0);
    step(1'b1, 8'hD4, 1'b0, 1'b0);
    idle(2);

    // Clear during the write bubble suppresses the write
    stream(NW);
    step(1'b1, 8'h77, 1'b0, 1'b1);
    stream(NW);
    idle(2);

    // Async reset after three words discards the partial instruction
    step(1'b1, 8'h01, 1'b0, 1'b0);
    step(1'b1, 8'h02, 1'b0, 1'b0);
    step(1'b1, 8'h03, 1'b0, 1'b0);
    do_reset();
    step(1'b1, 8'h9C, 1'b0, 1'b0);
    step(1'b1, 8'h8D, 1'b0, 1'b0);
    step(1'b1, 8'h7E, 1'b0, 1'b0);
    step(1'b1, 8'h6F, 1'b0, 1'b0);
    idle(2);

    // Randomized traffic with locks and occasional clears
    for (int i = 0; i < 2000; i++)
      step(($urandom % 4) != 0, WW'($urandom), ($urandom % 8) == 0, ($urandom % 150) == 0);

    idle(3);
    check("pending_writes", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
